// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status controller for a UART FIFO.
// Drives the write strobe and addresses of a dual-port register file whose
// read port is combinational, so the head word is always visible at r_addr.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  wpush;
  logic                  wpop;

  // Accept decisions; a pop while full frees the slot the push lands in,
  // and flush suppresses both requests.
  always_comb begin
    wpush = wr & ~clr & (~full | rd);
    wpop  = rd & ~clr & ~empty;
  end

  // Storage write strobe is held off while reset is asserted.
  assign wr_en = wpush & rst_n;

  // Pointers and occupancy; flush returns everything to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wpush) wr_ptr <= wr_ptr + PTR_ONE;
      if (wpop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({wpush, wpop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error bits record rejected requests until flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr & full & ~rd) ovf_q <= 1'b1;
      if (rd & empty)      unf_q <= 1'b1;
    end
  end

  // Status is decoded purely from registered state.
  assign w_addr       = wr_ptr;
  assign r_addr       = rd_ptr;
  assign count        = cnt;
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_CNT);
  assign almost_empty = (cnt <= AE_CNT);
  assign almost_full  = (cnt >= AF_CNT);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a queue-based model,
// a storage array driven by the DUT's strobe/addresses, a vector table,
// hand-written corner sequences and a randomized phase.
module tb_fifo_ctrl;

  localparam int ADDR_WIDTH = 2;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int AF_LEVEL   = DEPTH - 1;
  localparam int AE_LEVEL   = 1;

  logic                  clk;
  logic                  rst_n;
  logic                  wr;
  logic                  rd;
  logic                  clr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  logic [7:0] wdata;
  logic [7:0] mem [DEPTH];

  // Reference model: contents as a queue plus totals of accepted operations.
  logic [7:0] q [$];
  logic [7:0] popped [$];
  int         pushes;
  int         pops;
  bit         m_ovf;
  bit         m_unf;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       w;
    logic       r;
    logic       c;
    logic       exp_wr_en;
    int         exp_count;
    int         exp_waddr;
    int         exp_raddr;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t vecs [13];

  fifo_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .AF_LEVEL  (AF_LEVEL),
    .AE_LEVEL  (AE_LEVEL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wr),
    .rd          (rd),
    .clr         (clr),
    .wr_en       (wr_en),
    .w_addr      (w_addr),
    .r_addr      (r_addr),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side storage array written through the DUT's strobe and address.
  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= wdata;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    pushes = 0;
    pops   = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  // Compare all registered outputs plus the strobe for the pending request.
  task automatic checkOutput();
    int  n;
    bit  exp_we;
    n = q.size();
    exp_we = wr && !clr && (n < DEPTH || rd);
    chk("count",        32'(count),        32'(n));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("full",         32'(full),         32'(n == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
    chk("almost_full",  32'(almost_full),  32'(n >= AF_LEVEL));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_unf));
    chk("w_addr",       32'(w_addr),       32'(pushes % DEPTH));
    chk("r_addr",       32'(r_addr),       32'(pops % DEPTH));
    chk("wr_en",        32'(wr_en),        32'(exp_we));
    if (n > 0) chk("head_data", 32'(mem[r_addr]), 32'(q[0]));
  endtask

  // Drive one cycle of requests, check before the edge, then advance the model.
  task automatic applyStimulus(input logic w, input logic r, input logic c, input logic [7:0] d);
    bit pop_ok;
    bit push_ok;
    wr = w; rd = r; clr = c; wdata = d;
    #1;
    checkOutput();
    pop_ok  = r && !c && q.size() > 0;
    push_ok = w && !c && (q.size() < DEPTH || r);
    if (pop_ok) popped.push_back(mem[r_addr]);
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      if (w && !push_ok) m_ovf = 1'b1;
      if (r && q.size() == 0) m_unf = 1'b1;
      if (pop_ok) begin
        void'(q.pop_front());
        pops++;
      end
      if (push_ok) begin
        q.push_back(d);
        pushes++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    wr = 0; rd = 0; clr = 0; wdata = '0;
    rst_n = 1'b0;

    // Reset values while reset is held.
    #3;
    chk("rst_count",  32'(count), 0);
    chk("rst_empty",  32'(empty), 1);
    chk("rst_ae",     32'(almost_empty), 1);
    chk("rst_full",   32'(full), 0);
    chk("rst_af",     32'(almost_full), 0);
    chk("rst_wr_en",  32'(wr_en), 0);
    chk("rst_w_addr", 32'(w_addr), 0);
    chk("rst_r_addr", 32'(r_addr), 0);
    chk("rst_ovf",    32'(overflow), 0);
    chk("rst_unf",    32'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: fill/overflow, full rd&wr, drain/underflow, empty rd&wr, flush.
    //            w  r  c  we cnt wa ra ovf unf
    vecs[0]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 1, 2, 2, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 1, 3, 3, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 1, 4, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 4, 0, 0, 1, 0};
    vecs[5]  = '{1, 1, 0, 1, 4, 1, 1, 1, 0};
    vecs[6]  = '{0, 1, 0, 0, 3, 1, 2, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 2, 1, 3, 1, 0};
    vecs[8]  = '{0, 1, 0, 0, 1, 1, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 1, 1, 1, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 1, 1, 1, 1};
    vecs[11] = '{1, 1, 0, 1, 1, 2, 1, 1, 1};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      wr = vecs[i].w; rd = vecs[i].r; clr = vecs[i].c;
      #1;
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr_en));
      @(negedge clk);
      wr = 0; rd = 0; clr = 0;
      #1;
      chk($sformatf("vec%0d_count", i),  32'(count),     32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_w_addr", i), 32'(w_addr),    32'(vecs[i].exp_waddr));
      chk($sformatf("vec%0d_r_addr", i), 32'(r_addr),    32'(vecs[i].exp_raddr));
      chk($sformatf("vec%0d_ovf", i),    32'(overflow),  32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_unf", i),    32'(underflow), 32'(vecs[i].exp_unf));
    end
    @(negedge clk);
    model_reset();

    // Wrap-around ordering: A1..A6 through the model and the storage array.
    popped.delete();
    applyStimulus(1, 0, 0, 8'hA1);
    applyStimulus(1, 0, 0, 8'hA2);
    applyStimulus(1, 0, 0, 8'hA3);
    applyStimulus(1, 1, 0, 8'hA4);
    applyStimulus(1, 1, 0, 8'hA5);
    applyStimulus(1, 1, 0, 8'hA6);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    chk("wrap_pop_count", 32'(popped.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < popped.size()) chk($sformatf("wrap_pop%0d", i), 32'(popped[i]), 32'(8'hA1 + i));
    end

    // Flush with count=3 and overflow set, together with a write request.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 8'(8'h10 + i));
    applyStimulus(1, 0, 0, 8'h20);
    applyStimulus(0, 1, 0, 8'h00);
    chk("pre_clr_count", 32'(count), 3);
    chk("pre_clr_ovf",   32'(overflow), 1);
    applyStimulus(1, 0, 1, 8'h30);
    checkOutput();

    // Randomized traffic against the model, with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 29) == 0), 8'($urandom));
    end

    // Reset asserted mid-burst takes effect without a clock edge.
    applyStimulus(1, 0, 0, 8'h55);
    applyStimulus(1, 0, 0, 8'h56);
    wr = 1; rd = 0; clr = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count",  32'(count), 0);
    chk("mid_rst_empty",  32'(empty), 1);
    chk("mid_rst_full",   32'(full), 0);
    chk("mid_rst_ae",     32'(almost_empty), 1);
    chk("mid_rst_af",     32'(almost_full), 0);
    chk("mid_rst_wr_en",  32'(wr_en), 0);
    chk("mid_rst_w_addr", 32'(w_addr), 0);
    chk("mid_rst_r_addr", 32'(r_addr), 0);
    chk("mid_rst_ovf",    32'(overflow), 0);
    chk("mid_rst_unf",    32'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr = 0;
    model_reset();
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h77);
    checkOutput();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
